// File: rtl/fifo_pack_reader.sv
// Read-side FIFO consumer: pops DW-bit entries and packs RATIO of them (LSB lane first)
// into one wide word presented on a valid/ready stream; flush_i emits a partial word.
module fifo_pack_reader #(
  parameter int unsigned DW    = 8,
  parameter int unsigned RATIO = 4,
  parameter int unsigned CNTW  = $clog2(RATIO + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DW-1:0]       fifo_data_i,
  input  logic                fifo_empty_i,
  output logic                fifo_pop_o,
  input  logic                flush_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [RATIO*DW-1:0] m_data_o,
  output logic [CNTW-1:0]     m_cnt_o
);

  localparam int unsigned IDXW = $clog2(RATIO);
  localparam int unsigned WW   = RATIO * DW;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [WW-1:0]   data_q;
  logic            valid_q;
  logic [CNTW-1:0] cnt_q;
  logic            pop;

  // Popping in HOLD is only allowed on the handshake cycle, keeping one pop per cycle sustained.
  always_comb begin
    pop = 1'b0;
    if (!rst_i && !fifo_empty_i) begin
      pop = (state_q == FILL) || m_ready_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (pop) begin
            data_q[idx_q*DW +: DW] <= fifo_data_i;
          end
          if (pop && (idx_q == IDXW'(RATIO - 1))) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            cnt_q   <= CNTW'(RATIO);
            idx_q   <= '0;
          end else if (flush_i && ((idx_q != '0) || pop)) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            cnt_q   <= CNTW'(idx_q) + CNTW'(pop);
            idx_q   <= '0;
          end else if (pop) begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        HOLD: begin
          if (m_ready_i) begin
            state_q <= FILL;
            valid_q <= 1'b0;
            if (pop) begin
              data_q <= WW'(fifo_data_i);
              idx_q  <= IDXW'(1);
            end else begin
              data_q <= '0;
              idx_q  <= '0;
            end
          end
        end
        default: begin
          state_q <= FILL;
          valid_q <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign fifo_pop_o = pop;
  assign m_valid_o  = valid_q;
  assign m_data_o   = data_q;
  assign m_cnt_o    = cnt_q;

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Bench for fifo_pack_reader: a queue-based FIFO and packer model checked every cycle,
// plus directed scenarios with literal expected words.
module tb_fifo_pack_reader;

  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned CNTW  = $clog2(RATIO + 1);
  localparam int unsigned WW    = RATIO * DW;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [DW-1:0]   fifo_data_i;
  logic            fifo_empty_i;
  logic            fifo_pop_o;
  logic            flush_i;
  logic            m_valid_o;
  logic            m_ready_i;
  logic [WW-1:0]   m_data_o;
  logic [CNTW-1:0] m_cnt_o;

  fifo_pack_reader #(.DW(DW), .RATIO(RATIO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_pop_o  (fifo_pop_o),
    .flush_i     (flush_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_cnt_o     (m_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: FIFO contents, entries gathered so far, and the word on offer.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] acc[$];
  bit            mv   = 1'b0;
  logic [WW-1:0] word = '0;
  int unsigned   cnt  = 0;

  logic          obs_pop;
  logic          obs_valid;
  logic [WW-1:0] obs_data;
  logic [CNTW-1:0] obs_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pack_acc();
    logic [WW-1:0] w = '0;
    for (int i = 0; i < acc.size(); i++) w |= WW'(acc[i]) << (i * DW);
    return w;
  endfunction

  task automatic step(input bit fl, input bit rdy, input bit rs);
    bit exp_pop;
    @(negedge clk_i);
    rst_i        = rs;
    flush_i      = fl;
    m_ready_i    = rdy;
    fifo_empty_i = (fq.size() == 0);
    fifo_data_i  = (fq.size() == 0) ? DW'($urandom) : fq[0];
    #1;
    exp_pop   = !rs && (fq.size() != 0) && (!mv || rdy);
    obs_pop   = fifo_pop_o;
    obs_valid = m_valid_o;
    obs_data  = m_data_o;
    obs_cnt   = m_cnt_o;
    check("pop", 64'(fifo_pop_o), 64'(exp_pop));
    check("pop_when_empty", 64'(fifo_pop_o & fifo_empty_i), 64'(0));
    check("valid", 64'(m_valid_o), 64'(mv));
    check("data", 64'(m_data_o), 64'(mv ? word : pack_acc()));
    check("cnt", 64'(m_cnt_o), 64'(cnt));
    @(posedge clk_i);
    if (rs) begin
      acc.delete();
      mv   = 1'b0;
      word = '0;
      cnt  = 0;
    end else if (!mv) begin
      if (exp_pop) acc.push_back(fq.pop_front());
      if (acc.size() == RATIO || (fl && acc.size() != 0)) begin
        word = pack_acc();
        cnt  = acc.size();
        mv   = 1'b1;
        acc.delete();
      end
    end else if (rdy) begin
      mv = 1'b0;
      if (exp_pop) acc.push_back(fq.pop_front());
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; m_ready_i = 1'b0;
    fifo_empty_i = 1'b1; fifo_data_i = '0;
    repeat (2) @(posedge clk_i);
    step(0, 0, 1);
    check("reset_valid", 64'(obs_valid), 64'(0));
    check("reset_data", 64'(obs_data), 64'(0));
    check("reset_cnt", 64'(obs_cnt), 64'(0));

    // Full word with downstream always ready
    fq = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (4) step(0, 1, 0);
    step(0, 1, 0);
    check("t1_valid", 64'(obs_valid), 64'(1));
    check("t1_data", 64'(obs_data), 64'h44332211);
    check("t1_cnt", 64'(obs_cnt), 64'(4));
    step(0, 1, 0);
    check("t1_one_cycle", 64'(obs_valid), 64'(0));

    // Backpressure, then handshake with same-cycle pop
    fq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    repeat (4) step(0, 0, 0);
    repeat (3) begin
      step(0, 0, 0);
      check("t2_stall_pop", 64'(obs_pop), 64'(0));
      check("t2_hold_data", 64'(obs_data), 64'h44332211);
    end
    step(0, 1, 0);
    check("t2_hs_pop", 64'(obs_pop), 64'(1));
    repeat (3) step(0, 1, 0);
    step(0, 1, 0);
    check("t2_data", 64'(obs_data), 64'h88776655);
    check("t2_valid", 64'(obs_valid), 64'(1));

    // Partial word via flush, then a flush with nothing gathered
    fq = '{8'hA1, 8'hA2};
    repeat (3) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    check("t3_data", 64'(obs_data), 64'h0000A2A1);
    check("t3_cnt", 64'(obs_cnt), 64'(2));
    step(1, 1, 0);
    step(0, 1, 0);
    check("t3_no_empty_word", 64'(obs_valid), 64'(0));

    // Flush in the same cycle as a pop counts that entry
    fq = '{8'h01, 8'h02, 8'h03};
    repeat (2) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    check("t4_data", 64'(obs_data), 64'h00030201);
    check("t4_cnt", 64'(obs_cnt), 64'(3));

    // Reset mid-word discards gathered lanes
    fq = '{8'hE1, 8'hE2, 8'h5A, 8'h5B, 8'h5C, 8'h5D};
    repeat (2) step(0, 1, 0);
    step(0, 1, 1);
    check("t5_pop_in_reset", 64'(obs_pop), 64'(0));
    step(0, 1, 0);
    check("t5_rst_valid", 64'(obs_valid), 64'(0));
    check("t5_rst_data", 64'(obs_data), 64'(0));
    check("t5_rst_cnt", 64'(obs_cnt), 64'(0));
    repeat (3) step(0, 1, 0);
    step(0, 1, 0);
    check("t5_data", 64'(obs_data), 64'h5D5C5B5A);
    check("t5_cnt", 64'(obs_cnt), 64'(4));

    // Empty FIFO with random control: nothing may happen
    step(0, 1, 1);
    repeat (100) begin
      step(bit'($urandom_range(1)), bit'($urandom_range(1)), 0);
      check("t6_pop", 64'(obs_pop), 64'(0));
      check("t6_valid", 64'(obs_valid), 64'(0));
    end

    // Random traffic against the model
    repeat (3000) begin
      if ($urandom_range(2) != 0 && fq.size() < 16) fq.push_back(DW'($urandom));
      step(($urandom_range(7) == 0), ($urandom_range(3) != 0), ($urandom_range(249) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
